// File: rtl/pwm_pkg.sv
// Shared PWM definitions: default channel widths and the fade sequencer state type.
// Any PWM channel in the design pulls its default widths from here.
package pwm_pkg;

  localparam int unsigned DefCbits = 11;  // counter/duty width, period = 2^DefCbits clocks
  localparam int unsigned DefStepW = 4;   // ramp step width
  localparam int unsigned DefHoldW = 8;   // hold count width, in periods

  typedef enum logic [1:0] {
    StIdle,
    StRamp,
    StHold
  } fade_state_e;

endpackage

// File: rtl/pwm_core.sv
// PWM period counter and duty comparator.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   duty            candidate duty value from the sequencer
//   duty_load       request to apply 'duty'; honoured only on the period's last cycle
//   duty_cur        duty currently applied to the comparator
//   period_last     high while the counter sits at all-ones
//   pwm_out         registered PWM output (cnt < duty_cur)
//   period_start    registered pulse aligned with the first pwm_out cycle of a period
module pwm_core
  import pwm_pkg::*;
#(
  parameter int unsigned CBITS = DefCbits
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CBITS-1:0] duty,
  input  logic             duty_load,
  output logic [CBITS-1:0] duty_cur,
  output logic             period_last,
  output logic             pwm_out,
  output logic             period_start
);

  logic [CBITS-1:0] cnt_q;
  logic [CBITS-1:0] duty_q;
  logic             pwm_q;
  logic             period_start_q;

  assign period_last = &cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      duty_q         <= '0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_q + 1'b1;
      pwm_q          <= (cnt_q < duty_q);
      period_start_q <= (cnt_q == '0);
      // Gating on period_last keeps one duty value per period regardless of the caller.
      if (duty_load && period_last) begin
        duty_q <= duty;
      end
    end
  end

  assign duty_cur     = duty_q;
  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// LED PWM fade sequencer. Accepts fade commands (target, step, hold) over valid/ready
// and walks the applied duty toward the target one step per PWM period, then holds
// for 'hold'+1 periods before pulsing done.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (ready only while idle)
//   cmd_target/cmd_step/cmd_hold  command fields; step 0 acts as 1
//   abort                         stop the sequence, keep current duty, no done
//   pwm_out, period_start         PWM output and period marker
//   duty                          duty currently applied
//   busy                          sequence in progress
//   done                          one-cycle pulse on sequence completion
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned CBITS  = DefCbits,
  parameter int unsigned STEP_W = DefStepW,
  parameter int unsigned HOLD_W = DefHoldW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CBITS-1:0]  cmd_target,
  input  logic [STEP_W-1:0] cmd_step,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              abort,
  output logic              pwm_out,
  output logic              period_start,
  output logic [CBITS-1:0]  duty,
  output logic              busy,
  output logic              done
);

  // Wide enough that duty + step cannot wrap.
  localparam int unsigned SumW = ((CBITS > STEP_W) ? CBITS : STEP_W) + 1;

  fade_state_e       state_q;
  logic [CBITS-1:0]  target_q;
  logic [STEP_W-1:0] step_q;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] holdcnt_q;
  logic              done_q;

  logic [CBITS-1:0]  duty_cur;
  logic [CBITS-1:0]  ramp_duty;
  logic              duty_load;
  logic              period_last;

  pwm_core #(
    .CBITS(CBITS)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .duty        (ramp_duty),
    .duty_load   (duty_load),
    .duty_cur    (duty_cur),
    .period_last (period_last),
    .pwm_out     (pwm_out),
    .period_start(period_start)
  );

  // Next ramp value, clamped at the target from either direction.
  always_comb begin
    logic [SumW-1:0] duty_w;
    logic [SumW-1:0] tgt_w;
    logic [SumW-1:0] step_w;
    logic [SumW-1:0] sum_w;
    duty_w    = SumW'(duty_cur);
    tgt_w     = SumW'(target_q);
    step_w    = SumW'(step_q);
    sum_w     = duty_w + step_w;
    ramp_duty = target_q;
    if (duty_w < tgt_w) begin
      if (sum_w < tgt_w) begin
        ramp_duty = sum_w[CBITS-1:0];
      end
    end else begin
      if ((duty_w - tgt_w) > step_w) begin
        ramp_duty = CBITS'(duty_w - step_w);
      end
    end
  end

  assign duty_load = (state_q == StRamp) && period_last && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      target_q  <= '0;
      step_q    <= '0;
      hold_q    <= '0;
      holdcnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (cmd_valid) begin
              target_q <= cmd_target;
              step_q   <= (cmd_step == '0) ? STEP_W'(1) : cmd_step;
              hold_q   <= cmd_hold;
              if (cmd_target == duty_cur) begin
                state_q   <= StHold;
                holdcnt_q <= cmd_hold;
              end else begin
                state_q <= StRamp;
              end
            end
          end
          StRamp: begin
            if (period_last && (ramp_duty == target_q)) begin
              state_q   <= StHold;
              holdcnt_q <= hold_q;
            end
          end
          StHold: begin
            if (period_last) begin
              if (holdcnt_q == '0) begin
                done_q  <= 1'b1;
                state_q <= StIdle;
              end else begin
                holdcnt_q <= holdcnt_q - 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign duty      = duty_cur;
  assign done      = done_q;

endmodule
